out_uart_tx: RTL

Output stage of the 8-bit CPU. It captures the value driven on `bus` whenever the decoder asserts `c_oi` (the OUT instruction) and queues it in a small FIFO. It then shifts each byte out as an asynchronous serial frame on `tx`. It replaces a bare output register, so program output can be observed on a single pin or by a serial monitor in the bench.

---
 rtl/out_uart_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/out_uart_tx.sv
// CPU OUT port: captures bus on c_oi into a small FIFO and shifts each byte out as
// an async serial frame on tx (8N1; 8E1 when OUT_PARITY_EN is defined).
module out_uart_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DEPTH        = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             bus,
   input  logic                   c_oi,
   output logic                   tx,
   output logic                   full,
   output logic                   empty,
   output logic                   busy,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   // state  | meaning
   // IDLE   | line high, waiting for FIFO data
   // START  | start bit (low)
   // DATA   | eight data bits, LSB first
   // PARITY | even parity bit (OUT_PARITY_EN builds only)
   // STOP   | stop bit (high); may chain straight into the next START
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef OUT_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          wr_en, pop;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          baud_last;
`ifdef OUT_PARITY_EN
   logic          parity_q, parity_d;
`endif

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign wr_en     = c_oi && !full;
   assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (c_oi & full);
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage has no reset; clearing the pointers and count discards the contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= bus;
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + BW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
`ifdef OUT_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop      = 1'b1;
               shift_d  = mem_q[rd_ptr_q];
`ifdef OUT_PARITY_EN
               parity_d = ^mem_q[rd_ptr_q];
`endif
               state_d  = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef OUT_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
`ifdef OUT_PARITY_EN
         PARITY: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (!empty) begin
                  pop      = 1'b1;
                  shift_d  = mem_q[rd_ptr_q];
`ifdef OUT_PARITY_EN
                  parity_d = ^mem_q[rd_ptr_q];
`endif
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // tx is registered from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef OUT_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
`ifdef OUT_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
`ifdef OUT_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign tx       = tx_q;
   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;
   assign count    = count_q;

endmodule
